// File: rtl/trace_sequencer.sv
// Trace record FIFO and one-at-a-time issue sequencer for the multicore cache simulator.
// Optional WAIT timeout is enabled by defining SEQ_TIMEOUT_EN.
module trace_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [1:0]  in_core,
  input  logic        in_type,
  output logic        trace_ready,
  output logic [31:0] mem_addr,
  output logic [1:0]  core_id,
  output logic        ins_type,
  input  logic        updated,
  output logic        busy,
  output logic [19:0] issued_count,
  output logic [19:0] done_count,
  output logic [15:0] timeout_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [34:0]   fifo_mem [FIFO_DEPTH];
  logic          full, empty, push, pop, load, done_inc, gap_load;
  logic [GW-1:0] gap_cnt;
  logic          timed_out;

  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // wait_cnt is 0 in the first WAIT cycle, so the limit hits on the TIMEOUT_CYCLES-th cycle
  assign timed_out = (state == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  // A completion in the limit cycle wins over the timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      timeout_count <= '0;
    else if (timed_out && !updated)  timeout_count <= sat_inc16(timeout_count);
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timed_out      = 1'b0;
  assign timeout_count  = '0;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    done_inc  = 1'b0;
    gap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (updated || timed_out) begin
          done_inc = updated;
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            gap_load  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      gap_cnt      <= '0;
      trace_ready  <= 1'b0;
      mem_addr     <= '0;
      core_id      <= '0;
      ins_type     <= 1'b0;
      issued_count <= '0;
      done_count   <= '0;
    end else begin
      state       <= state_nxt;
      trace_ready <= load;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        issued_count <= sat_inc20(issued_count);
      end
      // Issue fields are captured on IDLE->ISSUE and held until the next issue
      if (load) {ins_type, core_id, mem_addr} <= fifo_mem[rd_ptr[AW-1:0]];
      if (done_inc) done_count <= sat_inc20(done_count);
      if (gap_load)           gap_cnt <= GW'(GAP_CYCLES);
      else if (state == GAP)  gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_type, in_core, in_addr};
  end

endmodule

// File: tb/tb_trace_sequencer.sv
// Randomized bench for trace_sequencer: two instances (GAP_CYCLES=2 and 0) checked
// every cycle against a timestamp-based transaction model.
module tb_trace_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, in_valid, in_type, updated;
  logic [31:0] in_addr;
  logic [1:0]  in_core;

  logic [1:0]        in_ready, trace_ready, ins_type, busy;
  logic [1:0][31:0]  mem_addr;
  logic [1:0][1:0]   core_id;
  logic [1:0][19:0]  issued_count, done_count;
  logic [1:0][15:0]  timeout_count;

  trace_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut_gap2 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_addr(in_addr), .in_core(in_core), .in_type(in_type), .trace_ready(trace_ready[0]),
    .mem_addr(mem_addr[0]), .core_id(core_id[0]), .ins_type(ins_type[0]), .updated(updated),
    .busy(busy[0]), .issued_count(issued_count[0]), .done_count(done_count[0]),
    .timeout_count(timeout_count[0]));

  trace_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_gap0 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_addr(in_addr), .in_core(in_core), .in_type(in_type), .trace_ready(trace_ready[1]),
    .mem_addr(mem_addr[1]), .core_id(core_id[1]), .ins_type(ins_type[1]), .updated(updated),
    .busy(busy[1]), .issued_count(issued_count[1]), .done_count(done_count[1]),
    .timeout_count(timeout_count[1]));

  // Model: pending records, the in-flight record's issue time, and the first cycle
  // in which the sequencer is back in IDLE after a completion.
  logic [34:0] mq [2][DEPTH];
  int          mhead [2];
  int          mcnt [2];
  bit          inflight [2];
  int          issue_cyc [2];
  int          free_cyc [2];
  logic [34:0] last_rec [2];
  int          m_iss [2];
  int          m_done [2];
  int          m_to [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; mcnt[i] = 0; inflight[i] = 1'b0; issue_cyc[i] = 0; free_cyc[i] = 0;
      last_rec[i] = '0; m_iss[i] = 0; m_done[i] = 0; m_to[i] = 0;
    end
  endtask

  task automatic check_outputs(input int i);
    string p;
    p = (i == 0) ? "gap2." : "gap0.";
    check({p, "trace_ready"}, 32'(trace_ready[i]), 32'(inflight[i] && issue_cyc[i] == cyc));
    check({p, "in_ready"}, 32'(in_ready[i]), 32'(mcnt[i] < DEPTH));
    check({p, "busy"}, 32'(busy[i]), 32'(inflight[i] || cyc < free_cyc[i] || mcnt[i] > 0));
    check({p, "mem_addr"}, mem_addr[i], last_rec[i][31:0]);
    check({p, "core_id"}, 32'(core_id[i]), 32'(last_rec[i][33:32]));
    check({p, "ins_type"}, 32'(ins_type[i]), 32'(last_rec[i][34]));
    check({p, "issued_count"}, 32'(issued_count[i]), 32'(m_iss[i]));
    check({p, "done_count"}, 32'(done_count[i]), 32'(m_done[i]));
    check({p, "timeout_count"}, 32'(timeout_count[i]), 32'(m_to[i]));
  endtask

  // Advance the model across the clock edge that ends the current cycle
  task automatic model_step(input int i);
    bit do_push;
    do_push = in_valid && (mcnt[i] < DEPTH);
    if (inflight[i]) begin
      if (cyc == issue_cyc[i]) begin
        mhead[i] = (mhead[i] + 1) % DEPTH;
        mcnt[i]--;
        m_iss[i]++;
      end else if (updated) begin
        m_done[i]++;
        inflight[i] = 1'b0;
        free_cyc[i] = cyc + gap_of(i) + 1;
      end else if (TO_EN && cyc == issue_cyc[i] + TO) begin
        m_to[i]++;
        inflight[i] = 1'b0;
        free_cyc[i] = cyc + gap_of(i) + 1;
      end
    end else if (cyc >= free_cyc[i] && enable && mcnt[i] > 0) begin
      inflight[i]  = 1'b1;
      issue_cyc[i] = cyc + 1;
      last_rec[i]  = mq[i][mhead[i]];
    end
    if (do_push) begin
      mq[i][(mhead[i] + mcnt[i]) % DEPTH] = {in_type, in_core, in_addr};
      mcnt[i]++;
    end
  endtask

  task automatic run_phase(input int n, input int pv, input int pu, input int pe);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) check_outputs(i);
      in_valid = (int'($urandom_range(99)) < pv);
      in_addr  = $urandom;
      in_core  = 2'($urandom);
      in_type  = 1'($urandom);
      updated  = (int'($urandom_range(99)) < pu);
      enable   = (int'($urandom_range(99)) < pe);
      for (int i = 0; i < 2; i++) model_step(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    updated  = 1'b0;
    enable   = 1'b0;
    @(negedge clk);
    model_reset();
    for (int i = 0; i < 2; i++) check_outputs(i);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_core  = '0;
    in_type  = 1'b0;
    updated  = 1'b0;
    model_reset();
    do_reset();
    run_phase(80, 10, 30, 100);   // sparse single records
    run_phase(30, 100, 0, 100);   // flood with no completions
    run_phase(60, 0, 40, 100);    // drain
    run_phase(150, 40, 30, 30);   // enable toggling
    run_phase(100, 20, 80, 100);  // frequent, often stray, completions
    run_phase(15, 100, 0, 100);   // fill queue, park in WAIT
    do_reset();
    run_phase(10, 0, 0, 100);     // nothing may issue after reset
    run_phase(150, 50, 30, 90);
    run_phase(200, 30, 20, 80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
